// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory req/ack, output buffer valid/ready
// and execute-stage redirect. The master modport is the fetch unit's side.
interface instr_fetch_unit_if #(
    parameter int unsigned PC_WIDTH = 9
);
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_ack;
    logic [31:0]         imem_rdata;
    logic                instr_valid;
    logic                instr_ready;
    logic [31:0]         instr;
    logic [PC_WIDTH-1:0] instr_pc;
    logic                redirect_valid;
    logic [PC_WIDTH-1:0] redirect_target;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output instr_valid, instr, instr_pc,
        input  instr_ready,
        input  redirect_valid, redirect_target
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  instr_valid, instr, instr_pc,
        output instr_ready,
        output redirect_valid, redirect_target
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end: PC, single-outstanding imem req/ack, one-entry output
// buffer, redirects and halt detection. FETCH_COUNT_EN adds a delivered-instruction counter.
module instr_fetch_unit #(
    parameter int unsigned         PC_WIDTH = 9,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    instr_fetch_unit_if.master bus,
    output logic               halted
`ifdef FETCH_COUNT_EN
    ,
    output logic [31:0]        fetch_count
`endif
);

    // Encoding puts imem_req in bit 0 and halted in bit 2 so both come straight off flops.
    typedef enum logic [2:0] {
        StReady  = 3'b000,
        StBusy   = 3'b001,
        StFlush  = 3'b011,
        StHalted = 3'b100
    } state_e;

    state_e              state_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] addr_q;
    logic [31:0]         instr_q;
    logic [PC_WIDTH-1:0] instr_pc_q;
    logic                valid_q;

    logic                handshake;
    logic                halt_fetched;
    logic [PC_WIDTH-1:0] target;
    logic [PC_WIDTH-1:0] next_seq_pc;

    assign handshake    = valid_q & bus.instr_ready;
    assign halt_fetched = (bus.imem_rdata[6:0] == 7'b1111111);
    assign target       = bus.redirect_target & ~PC_WIDTH'(3);
    assign next_seq_pc  = addr_q + PC_WIDTH'(4);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StReady;
            pc_q       <= RESET_PC;
            addr_q     <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            // Delivery or any redirect empties the buffer; a BUSY ack below may refill it.
            if (handshake || bus.redirect_valid) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                StReady: begin
                    if (bus.redirect_valid) begin
                        pc_q <= target;
                    end else if (!valid_q || handshake) begin
                        state_q <= StBusy;
                        addr_q  <= pc_q;
                    end
                end
                StBusy: begin
                    if (bus.redirect_valid) begin
                        pc_q    <= target;
                        state_q <= bus.imem_ack ? StReady : StFlush;
                    end else if (bus.imem_ack) begin
                        instr_q    <= bus.imem_rdata;
                        instr_pc_q <= addr_q;
                        valid_q    <= 1'b1;
                        pc_q       <= next_seq_pc;
                        state_q    <= halt_fetched ? StHalted : StReady;
                    end
                end
                StFlush: begin
                    // Request stays at the stale address until memory answers it.
                    if (bus.redirect_valid) begin
                        pc_q <= target;
                    end
                    if (bus.imem_ack) begin
                        state_q <= StReady;
                    end
                end
                StHalted: begin
                    if (bus.redirect_valid) begin
                        pc_q    <= target;
                        state_q <= StReady;
                    end
                end
                default: state_q <= StReady;
            endcase
        end
    end

    assign bus.imem_req    = state_q[0];
    assign bus.imem_addr   = addr_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign halted          = state_q[2];

`ifdef FETCH_COUNT_EN
    logic [31:0] count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (handshake && (count_q != 32'hFFFF_FFFF)) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign fetch_count = count_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a memory responder checks request addresses and an
// output monitor checks delivered instructions against queues filled by the directed steps.
module tb_instr_fetch_unit;
    localparam int unsigned PCW = 9;

    typedef struct packed {
        logic [31:0]    word;
        logic [PCW-1:0] pc;
    } out_t;

    logic        clk;
    logic        rst_n;
    logic        halted;
    logic [31:0] fetch_count;

    instr_fetch_unit_if #(.PC_WIDTH(PCW)) bus ();

    instr_fetch_unit #(
        .PC_WIDTH(PCW),
        .RESET_PC(9'h000)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus),
        .halted(halted)
`ifdef FETCH_COUNT_EN
        ,
        .fetch_count(fetch_count)
`endif
    );

`ifndef FETCH_COUNT_EN
    assign fetch_count = 32'd0;
`endif

    int             checks = 0;
    int             passed = 0;
    int             hs_count = 0;
    int             mem_wait = 0;
    int             halt_addr = -1;
    logic [PCW-1:0] exp_req[$];
    out_t           exp_out[$];

    bit             mem_busy = 1'b0;
    int             mem_cnt = 0;
    logic [PCW-1:0] mem_addr;
    logic [PCW-1:0] exp_addr;
    out_t           exp_item;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d passed=%0d", checks, passed);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [PCW-1:0] a);
        if (halt_addr == int'(a)) return 32'h0000_007F;
        return {14'h1A5A, a, 2'b00, 7'h13};
    endfunction

    task automatic push_out(input logic [PCW-1:0] a);
        out_t item;
        item.word = mem_word(a);
        item.pc   = a;
        exp_out.push_back(item);
    endtask

    task automatic wait_valid(input string tag, input int max);
        int n = 0;
        while (!bus.instr_valid && n < max) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(bus.instr_valid), 32'd1);
    endtask

    task automatic redirect(input logic [PCW-1:0] t);
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = t;
        @(negedge clk);
        bus.redirect_valid  = 1'b0;
    endtask

    // Instruction memory: acks after mem_wait wait cycles, checks each new request address.
    initial begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            bus.imem_ack = 1'b0;
            if (!rst_n || !bus.imem_req) begin
                mem_busy = 1'b0;
            end else begin
                if (!mem_busy) begin
                    mem_busy = 1'b1;
                    mem_cnt  = 0;
                    mem_addr = bus.imem_addr;
                    check("req_expected", 32'(exp_req.size() > 0), 32'd1);
                    if (exp_req.size() > 0) begin
                        exp_addr = exp_req.pop_front();
                        check("req_addr", 32'(bus.imem_addr), 32'(exp_addr));
                    end
                end else begin
                    check("req_addr_stable", 32'(bus.imem_addr), 32'(mem_addr));
                end
                if (mem_cnt >= mem_wait) begin
                    bus.imem_ack   = 1'b1;
                    bus.imem_rdata = mem_word(mem_addr);
                    mem_busy       = 1'b0;
                end else begin
                    mem_cnt++;
                end
            end
        end
    end

    // Output monitor: every handshake pops one expected instruction.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                hs_count = 0;
            end else if (bus.instr_valid && bus.instr_ready) begin
                hs_count++;
                check("out_expected", 32'(exp_out.size() > 0), 32'd1);
                if (exp_out.size() > 0) begin
                    exp_item = exp_out.pop_front();
                    check("out_instr", bus.instr, exp_item.word);
                    check("out_pc", 32'(bus.instr_pc), 32'(exp_item.pc));
                end
            end
        end
    end

    initial begin
        rst_n               = 1'b0;
        bus.instr_ready     = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = '0;
        repeat (2) @(negedge clk);
        check("rst_req", 32'(bus.imem_req), 32'd0);
        check("rst_addr", 32'(bus.imem_addr), 32'd0);
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_instr", bus.instr, 32'd0);
        check("rst_instr_pc", 32'(bus.instr_pc), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
`ifdef FETCH_COUNT_EN
        check("rst_count", fetch_count, 32'd0);
`endif

        // Zero-wait memory, always ready: one instruction every second cycle.
        exp_req.push_back(9'h000);
        exp_req.push_back(9'h004);
        exp_req.push_back(9'h008);
        push_out(9'h000);
        push_out(9'h004);
        push_out(9'h008);
        bus.instr_ready = 1'b1;
        rst_n           = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check("t1_valid_pattern", 32'(bus.instr_valid), 32'(i % 2 == 0));
        end
        bus.instr_ready = 1'b0;

        // Stalled consumer holds the buffer and blocks new requests; then a 3-wait fetch.
        mem_wait = 3;
        repeat (5) begin
            @(negedge clk);
            check("t2_hold_instr", bus.instr, mem_word(9'h008));
            check("t2_hold_pc", 32'(bus.instr_pc), 32'h008);
            check("t2_no_req", 32'(bus.imem_req), 32'd0);
        end
        exp_req.push_back(9'h00C);
        push_out(9'h00C);
        bus.instr_ready = 1'b1;
        @(negedge clk);
        bus.instr_ready = 1'b0;
`ifdef FETCH_COUNT_EN
        check("t2_count", fetch_count, 32'(hs_count));
`endif
        repeat (4) begin
            check("t2_req_held", 32'(bus.imem_req), 32'd1);
            check("t2_addr_held", 32'(bus.imem_addr), 32'h00C);
            @(negedge clk);
        end
        check("t2_valid", 32'(bus.instr_valid), 32'd1);
        check("t2_pc", 32'(bus.instr_pc), 32'h00C);
        check("t2_req_done", 32'(bus.imem_req), 32'd0);

        // Redirect before ack: FLUSH drops the late data, then fetch resumes at the target.
        exp_req.push_back(9'h010);
        exp_req.push_back(9'h040);
        bus.instr_ready = 1'b1;
        @(negedge clk);
        bus.instr_ready = 1'b0;
        check("t3_busy", 32'(bus.imem_req), 32'd1);
        redirect(9'h040);
        check("t3_flush_req", 32'(bus.imem_req), 32'd1);
        check("t3_flush_addr", 32'(bus.imem_addr), 32'h010);
        repeat (4) begin
            @(negedge clk);
            check("t3_dropped", 32'(bus.instr_valid), 32'd0);
        end
        wait_valid("t3_valid", 12);
        check("t3_pc", 32'(bus.instr_pc), 32'h040);
        check("t3_instr", bus.instr, mem_word(9'h040));

        // Halt opcode at 0x00C stops fetching until a redirect.
        mem_wait  = 0;
        halt_addr = 'h00C;
        exp_req.push_back(9'h00C);
        push_out(9'h00C);
        redirect(9'h00C);
        check("t4_redirect_clears", 32'(bus.instr_valid), 32'd0);
        @(negedge clk);
        check("t4_busy", 32'(bus.imem_req), 32'd1);
        check("t4_not_halted", 32'(halted), 32'd0);
        @(negedge clk);
        check("t4_valid", 32'(bus.instr_valid), 32'd1);
        check("t4_instr", bus.instr, 32'h0000_007F);
        check("t4_halted", 32'(halted), 32'd1);
        halt_addr = -1;
        repeat (10) begin
            @(negedge clk);
            check("t4_no_req", 32'(bus.imem_req), 32'd0);
            check("t4_still_halted", 32'(halted), 32'd1);
        end
        bus.instr_ready = 1'b1;
        @(negedge clk);
        bus.instr_ready = 1'b0;
        check("t4_consumed", 32'(bus.instr_valid), 32'd0);
        check("t4_halt_kept", 32'(halted), 32'd1);
        exp_req.push_back(9'h020);
        redirect(9'h020);
        check("t4_resumed", 32'(halted), 32'd0);
        wait_valid("t4_resume_valid", 10);
        check("t4_resume_pc", 32'(bus.instr_pc), 32'h020);

        // PC wraps from 0x1FC to 0x000; unaligned redirect target is word-aligned.
        exp_req.push_back(9'h1FC);
        exp_req.push_back(9'h000);
        push_out(9'h1FC);
        redirect(9'h1FC);
        bus.instr_ready = 1'b1;
        wait_valid("t5_valid_top", 10);
        @(negedge clk);
        wait_valid("t5_valid_wrap", 10);
        bus.instr_ready = 1'b0;
        check("t5_wrap_pc", 32'(bus.instr_pc), 32'h000);
        check("t5_wrap_instr", bus.instr, mem_word(9'h000));
        exp_req.push_back(9'h010);
        redirect(9'h013);
        check("t5_cleared", 32'(bus.instr_valid), 32'd0);
        wait_valid("t5_valid_align", 10);
        check("t5_align_pc", 32'(bus.instr_pc), 32'h010);
`ifdef FETCH_COUNT_EN
        check("t5_count", fetch_count, 32'(hs_count));
`endif

        // Asynchronous reset in the middle of a BUSY transaction.
        mem_wait = 5;
        exp_req.push_back(9'h080);
        redirect(9'h080);
        @(negedge clk);
        check("t6_busy", 32'(bus.imem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_req", 32'(bus.imem_req), 32'd0);
        check("t6_rst_valid", 32'(bus.instr_valid), 32'd0);
        check("t6_rst_halted", 32'(halted), 32'd0);
        check("t6_rst_instr_pc", 32'(bus.instr_pc), 32'd0);
`ifdef FETCH_COUNT_EN
        check("t6_rst_count", fetch_count, 32'd0);
`endif
        repeat (2) @(negedge clk);
        mem_wait = 0;
        exp_req.push_back(9'h000);
        rst_n = 1'b1;
        wait_valid("t6_restart_valid", 10);
        check("t6_restart_pc", 32'(bus.instr_pc), 32'h000);
        check("t6_restart_instr", bus.instr, mem_word(9'h000));

        check("end_req_queue", 32'(exp_req.size()), 32'd0);
        check("end_out_queue", 32'(exp_out.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction-fetch front end for the single-cycle/multi-cycle RISC-V core; it produces the 32-bit instruction whose opcode field drives the control decoder.
- Owns the PC and runs a req/ack handshake to instruction memory.
- Holds one fetched instruction in a valid/ready output buffer.
- Accepts redirects (taken branch, jal, jalr) from execute and stops fetching after it fetches the halt opcode 7'b1111111.

Parameters:
- PC_WIDTH, 9, byte-address width of PC and imem address.
- RESET_PC, 0, PC value loaded on reset (width PC_WIDTH).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request; high in BUSY and FLUSH.
- imem_addr  out  PC_WIDTH  fetch address; stable while imem_req high.
- imem_ack  in  1  memory response strobe; imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction.
- instr_valid  out  1  output buffer holds an instruction.
- instr_ready  in  1  downstream accepts the instruction.
- instr  out  32  buffered instruction.
- instr_pc  out  PC_WIDTH  address of the buffered instruction.
- redirect_valid  in  1  one-cycle redirect (branch taken / jump).
- redirect_target  in  PC_WIDTH  redirect address; bits [1:0] forced to 0.
- halted  out  1  high while in HALTED.

Behaviour:
- Reset while low, asynchronous:
  - state=READY, pc=RESET_PC, imem_addr=0, instr_valid=0.
  - instr=0, instr_pc=0, halted=0, imem_req=0.
  - Any outstanding memory transaction is abandoned; memory must tolerate this.
- FSM states: READY, BUSY, FLUSH, HALTED. imem_req=(state==BUSY||state==FLUSH); halted=(state==HALTED).
- One outstanding request maximum. imem_addr is a register loaded from pc on READY->BUSY and never changes while imem_req is high.
- READY:
  - redirect_valid -> pc=target; stay READY.
  - Otherwise, if !instr_valid or (instr_valid&&instr_ready) -> BUSY with imem_addr=pc.
- BUSY:
  - imem_ack and no redirect -> instr=imem_rdata, instr_pc=imem_addr, instr_valid=1, pc=imem_addr+4 (wraps mod 2^PC_WIDTH).
  - Next state is HALTED if imem_rdata[6:0]==7'b1111111, else READY.
  - redirect_valid with imem_ack -> data discarded, pc=target, READY.
  - redirect_valid without imem_ack -> pc=target, FLUSH.
- FLUSH:
  - Req held at the old address until ack.
  - imem_ack -> data discarded, READY.
  - redirect_valid in FLUSH -> pc=new target; the latest redirect wins.
- HALTED:
  - No requests issued.
  - Halt instruction stays buffered until consumed.
  - redirect_valid -> pc=target, READY. This cancels a halt fetched on a wrong path.
- Output buffer:
  - Handshake completes on instr_valid&&instr_ready.
  - instr and instr_pc are held stable while valid&&!ready.
  - Buffer is cleared on completion unless reloaded by ack that cycle.
  - Any redirect_valid clears instr_valid next cycle. A same-cycle valid&&ready counts as delivered.
- Latency and throughput:
  - Ack in cycle N -> instr_valid in N+1.
  - Earliest next imem_req is N+2.
  - Peak throughput is 1 instruction per 2 cycles with zero-wait memory (ack in the first req cycle).
- Buffer cannot overflow: a request issues only when the buffer is empty or emptying.

Optional Feature:
- Macro: FETCH_COUNT_EN.
- Defined:
  - Adds output port fetch_count [31:0].
  - Counts completed output handshakes, including the halt instruction.
  - Saturates at 32'hFFFF_FFFF; reset to 0.
  - Unaffected by redirects.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release, memory acks in the first req cycle, instr_ready=1 -> imem_addr sequence 0x000, 0x004, 0x008; instr_valid every 2nd cycle; instr_pc matches each address.
- Memory acks after 3 wait cycles, instr_ready=0 for 5 cycles -> imem_addr stable through the wait; instr/instr_pc held; no new req until the buffer is consumed.
- redirect_valid=1, target=0x040, during BUSY before ack -> FLUSH; the late ack's data is dropped (instr_valid stays 0); next request at 0x040.
- Fetch imem_rdata=32'h0000007F at 0x00C -> instr_valid with that word, halted=1 next cycle, imem_req stays 0 for 10 cycles; a redirect to 0x020 then resumes fetching at 0x020 with halted=0.
- PC=2^PC_WIDTH-4 (0x1FC) fetched -> next imem_addr 0x000. redirect_target=0x013 -> fetch at 0x010.
- Assert reset mid-BUSY -> imem_req, instr_valid and halted drop asynchronously; after release the first fetch is at RESET_PC. With FETCH_COUNT_EN, 3 handshakes -> fetch_count=3, and it is 0 after reset.
